// File: rtl/mips_decode_exec_if.sv
// Bundle for the decode/execute stage: instruction and operands in, registered
// control flags and ALU results out. There is no valid/ready pair: inputs are consumed every cycle.
interface mips_decode_exec_if;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;

    logic        regdst;
    logic        branch_eq;
    logic        branch_ne;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic        alusrc;
    logic        jump;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_result;
    logic        zero;
    logic [4:0]  wrreg;

    modport master (
        output instr, rs_data, rt_data, stall,
        input  regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
        input  regwrite, alusrc, jump, aluop, aluctl, alu_result, zero, wrreg
    );

    modport slave (
        input  instr, rs_data, rt_data, stall,
        output regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
        output regwrite, alusrc, jump, aluop, aluctl, alu_result, zero, wrreg
    );
endinterface

// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS opcode decode, ALU control and ALU, with every output
// registered once. Stall only bubbles the control flags and aluctl; the datapath keeps running.
module mips_decode_exec (
    input  logic                clk,
    input  logic                rst_n,
    mips_decode_exec_if.slave   bus
);
    typedef struct packed {
        logic       regdst;
        logic       branch_eq;
        logic       branch_ne;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    logic [5:0]  opcode;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [15:0] imm;
    logic [5:0]  funct;

    assign opcode = bus.instr[31:26];
    assign rt_f   = bus.instr[20:16];
    assign rd_f   = bus.instr[15:11];
    assign imm    = bus.instr[15:0];
    assign funct  = bus.instr[5:0];

    ctrl_t       dec;
    logic [3:0]  aluctl_dec;
    logic [31:0] op_b;
    logic [31:0] alu_c;

    ctrl_t       ctrl_d,       ctrl_q;
    logic [3:0]  aluctl_d,     aluctl_q;
    logic [31:0] alu_result_d, alu_result_q;
    logic        zero_d,       zero_q;
    logic [4:0]  wrreg_d,      wrreg_q;

    always_comb begin
        dec = '0;
        case (opcode)
            6'b000000: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
            end
            6'b100011: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
            end
            6'b101011: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            6'b000100: begin
                dec.branch_eq = 1'b1;
                dec.aluop     = 2'b01;
            end
            6'b000101: begin
                dec.branch_ne = 1'b1;
                dec.aluop     = 2'b01;
            end
            6'b001000: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            6'b000010: dec.jump = 1'b1;
            default:   dec = '0;
        endcase
    end

    always_comb begin
        aluctl_dec = 4'b1111;
        case (dec.aluop)
            2'b00: aluctl_dec = 4'b0010;
            2'b01: aluctl_dec = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: aluctl_dec = 4'b0010;
                    6'b100010: aluctl_dec = 4'b0110;
                    6'b100100: aluctl_dec = 4'b0000;
                    6'b100101: aluctl_dec = 4'b0001;
                    6'b101010: aluctl_dec = 4'b0111;
                    6'b100111: aluctl_dec = 4'b1100;
                    default:   aluctl_dec = 4'b1111;
                endcase
            end
            default: aluctl_dec = 4'b1111;
        endcase
    end

    // The ALU always follows the unstalled decode so a bubble still yields the computed result.
    always_comb begin
        op_b  = dec.alusrc ? {{16{imm[15]}}, imm} : bus.rt_data;
        alu_c = 32'd0;
        case (aluctl_dec)
            4'b0010: alu_c = bus.rs_data + op_b;
            4'b0110: alu_c = bus.rs_data - op_b;
            4'b0000: alu_c = bus.rs_data & op_b;
            4'b0001: alu_c = bus.rs_data | op_b;
            4'b0111: alu_c = {31'd0, $signed(bus.rs_data) < $signed(op_b)};
            4'b1100: alu_c = ~(bus.rs_data | op_b);
            default: alu_c = 32'd0;
        endcase
    end

    always_comb begin
        ctrl_d       = bus.stall ? '0 : dec;
        aluctl_d     = bus.stall ? 4'b1111 : aluctl_dec;
        alu_result_d = alu_c;
        zero_d       = (alu_c == 32'd0);
        wrreg_d      = dec.regdst ? rd_f : rt_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            aluctl_q     <= 4'b0000;
            alu_result_q <= 32'd0;
            zero_q       <= 1'b0;
            wrreg_q      <= 5'd0;
        end else begin
            ctrl_q       <= ctrl_d;
            aluctl_q     <= aluctl_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            wrreg_q      <= wrreg_d;
        end
    end

    assign bus.regdst     = ctrl_q.regdst;
    assign bus.branch_eq  = ctrl_q.branch_eq;
    assign bus.branch_ne  = ctrl_q.branch_ne;
    assign bus.memread    = ctrl_q.memread;
    assign bus.memwrite   = ctrl_q.memwrite;
    assign bus.memtoreg   = ctrl_q.memtoreg;
    assign bus.regwrite   = ctrl_q.regwrite;
    assign bus.alusrc     = ctrl_q.alusrc;
    assign bus.jump       = ctrl_q.jump;
    assign bus.aluop      = ctrl_q.aluop;
    assign bus.aluctl     = aluctl_q;
    assign bus.alu_result = alu_result_q;
    assign bus.zero       = zero_q;
    assign bus.wrreg      = wrreg_q;
endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed-vector bench for mips_decode_exec: a table of hand-computed
// records plus short reset and latency sequences.
module tb_mips_decode_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mips_decode_exec_if bus();

    mips_decode_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // flags order: regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
        logic [8:0]  flags;
        logic [1:0]  aluop;
        logic [3:0]  aluctl;
        logic [31:0] res;
        logic        zero;
        logic [4:0]  wrreg;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] get_flags();
        return {bus.regdst, bus.branch_eq, bus.branch_ne, bus.memread, bus.memwrite,
                bus.memtoreg, bus.regwrite, bus.alusrc, bus.jump};
    endfunction

    function automatic logic [52:0] all_outputs();
        return {get_flags(), bus.aluop, bus.aluctl, bus.alu_result, bus.zero, bus.wrreg};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic stall);
        bus.instr   = instr;
        bus.rs_data = rs;
        bus.rt_data = rt;
        bus.stall   = stall;
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] rs,
                           input logic [31:0] rt, input logic stall, input logic [8:0] flags,
                           input logic [1:0] aluop, input logic [3:0] aluctl,
                           input logic [31:0] res, input logic zero, input logic [4:0] wrreg);
        vec_t v;
        v.name = name; v.instr = instr; v.rs = rs; v.rt = rt; v.stall = stall;
        v.flags = flags; v.aluop = aluop; v.aluctl = aluctl;
        v.res = res; v.zero = zero; v.wrreg = wrreg;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("add",       32'h00221820, 32'd5,        32'd7,        1'b0, 9'b100000100, 2'b10, 4'b0010, 32'd12,       1'b0, 5'd3);
        add_vec("lw_neg",    32'h8C41FFFC, 32'h100,      32'h55,       1'b0, 9'b000101110, 2'b00, 4'b0010, 32'hFC,       1'b0, 5'd1);
        add_vec("beq_eq",    32'h10220005, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 9'b010000000, 2'b01, 4'b0110, 32'd0,        1'b1, 5'd2);
        add_vec("slt_neg",   32'h0022182A, 32'hFFFFFFFF, 32'd1,        1'b0, 9'b100000100, 2'b10, 4'b0111, 32'd1,        1'b0, 5'd3);
        add_vec("slt_swap",  32'h0022182A, 32'd1,        32'hFFFFFFFF, 1'b0, 9'b100000100, 2'b10, 4'b0111, 32'd0,        1'b1, 5'd3);
        add_vec("nor_zero",  32'h00221827, 32'd0,        32'd0,        1'b0, 9'b100000100, 2'b10, 4'b1100, 32'hFFFFFFFF, 1'b0, 5'd3);
        add_vec("bad_funct", 32'h00221801, 32'd9,        32'd4,        1'b0, 9'b100000100, 2'b10, 4'b1111, 32'd0,        1'b1, 5'd3);
        add_vec("sw_stall",  32'hAC410008, 32'h200,      32'h77,       1'b1, 9'b000000000, 2'b00, 4'b1111, 32'h208,      1'b0, 5'd1);
        add_vec("sw",        32'hAC410008, 32'h200,      32'h77,       1'b0, 9'b000010010, 2'b00, 4'b0010, 32'h208,      1'b0, 5'd1);
        add_vec("bne_eq",    32'h14220003, 32'd5,        32'd5,        1'b0, 9'b001000000, 2'b01, 4'b0110, 32'd0,        1'b1, 5'd2);
        add_vec("addi_neg",  32'h2022FFFF, 32'd0,        32'd99,       1'b0, 9'b000000110, 2'b00, 4'b0010, 32'hFFFFFFFF, 1'b0, 5'd2);
        add_vec("jump",      32'h08000010, 32'd3,        32'd4,        1'b0, 9'b000000001, 2'b00, 4'b0010, 32'd7,        1'b0, 5'd0);
        add_vec("unk_op",    32'h3C011234, 32'd10,       32'd20,       1'b0, 9'b000000000, 2'b00, 4'b0010, 32'd30,       1'b0, 5'd1);
        add_vec("and",       32'h00221824, 32'hF0F0,     32'hFF00,     1'b0, 9'b100000100, 2'b10, 4'b0000, 32'hF000,     1'b0, 5'd3);
        add_vec("or",        32'h00221825, 32'hF0F0,     32'hFF00,     1'b0, 9'b100000100, 2'b10, 4'b0001, 32'hFFF0,     1'b0, 5'd3);
        add_vec("sub_neg",   32'h00221822, 32'd3,        32'd5,        1'b0, 9'b100000100, 2'b10, 4'b0110, 32'hFFFFFFFE, 1'b0, 5'd3);
        add_vec("add_ovf",   32'h00221820, 32'h7FFFFFFF, 32'd1,        1'b0, 9'b100000100, 2'b10, 4'b0010, 32'h80000000, 1'b0, 5'd3);
        add_vec("r_stall",   32'h00221822, 32'd8,        32'd8,        1'b1, 9'b000000000, 2'b00, 4'b1111, 32'd0,        1'b1, 5'd3);

        drive(32'h0, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async", 32'(all_outputs() == 53'd0), 32'd1);
        check("reset_aluctl", {28'd0, bus.aluctl}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        drive(32'h00221820, 32'd5, 32'd7, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_edge_res", bus.alu_result, 32'd12);
        check("first_edge_wrreg", {27'd0, bus.wrreg}, 32'd3);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].stall);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_flags"},  {23'd0, get_flags()},   {23'd0, vecs[i].flags});
            check({vecs[i].name, "_aluop"},  {30'd0, bus.aluop},     {30'd0, vecs[i].aluop});
            check({vecs[i].name, "_aluctl"}, {28'd0, bus.aluctl},    {28'd0, vecs[i].aluctl});
            check({vecs[i].name, "_result"}, bus.alu_result,         vecs[i].res);
            check({vecs[i].name, "_zero"},   {31'd0, bus.zero},      {31'd0, vecs[i].zero});
            check({vecs[i].name, "_wrreg"},  {27'd0, bus.wrreg},     {27'd0, vecs[i].wrreg});
        end

        // Outputs hold until the edge: new inputs must not leak through combinationally.
        @(negedge clk);
        drive(32'h00221820, 32'd100, 32'd23, 1'b0);
        #1 check("hold_before_edge", bus.alu_result, 32'd0);
        @(posedge clk);
        #1 check("latency_one", bus.alu_result, 32'd123);
        check("latency_regwrite", {31'd0, bus.regwrite}, 32'd1);

        // Reset mid-cycle clears everything before the next edge.
        #3 rst_n = 1'b0;
        #1 check("reset_mid", 32'(all_outputs() == 53'd0), 32'd1);
        @(posedge clk);
        #1 check("reset_hold", 32'(all_outputs() == 53'd0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h8C41FFFC, 32'h100, 32'h0, 1'b0);
        @(posedge clk);
        #1 check("post_reset_lw", bus.alu_result, 32'hFC);
        check("post_reset_memread", {31'd0, bus.memread}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want done");
        $fatal(1, "timeout");
    end
endmodule
